// File: rtl/rho_pkg.sv
// Shared types and rho offset table for the rho lane-rotation engine.
package rho_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } rho_state_e;

    // Keccak rho offsets indexed by lane_id = x + 5y.
    localparam logic [5:0] RHO_OFFSET [0:24] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    // Offset reduced mod lane_w; ids beyond the 5x5 state rotate by zero.
    function automatic logic [5:0] rho_offset(input logic [4:0] lane_id, input int lane_w);
        if (lane_id > 5'd24)
            return 6'd0;
        return RHO_OFFSET[lane_id] & 6'(lane_w - 1);
    endfunction

endpackage

// File: rtl/rho_bit_slice.sv
// Picks the BITS_PER_CYC source bits that land at lane positions z..z+BITS_PER_CYC-1.
module rho_bit_slice #(
    parameter int LANE_W       = 64,
    parameter int BITS_PER_CYC = 1,
    parameter int Z_W          = $clog2(LANE_W)
) (
    input  logic [LANE_W-1:0]       src,
    input  logic [Z_W-1:0]          z,
    input  logic [Z_W-1:0]          r,
    output logic [BITS_PER_CYC-1:0] bits
);

    // Index arithmetic wraps naturally in Z_W bits, giving mod LANE_W for free.
    for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_bit
        logic [Z_W-1:0] idx;
        assign idx     = z + Z_W'(k) - r;
        assign bits[k] = src[idx];
    end

endmodule

// File: rtl/rho_rotate_engine.sv
// Keccak rho lane rotator, BITS_PER_CYC bits per cycle with valid/ready on both sides.
// Optional macro RHO_OFFSET_OVERRIDE_EN adds ofs_sel/ofs_val to replace the table offset.
module rho_rotate_engine
    import rho_pkg::*;
#(
    parameter int LANE_W       = 64,
    parameter int BITS_PER_CYC = 1,
    parameter int Z_W          = $clog2(LANE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] lane_in,
    input  logic [4:0]        lane_id,
`ifdef RHO_OFFSET_OVERRIDE_EN
    input  logic              ofs_sel,
    input  logic [5:0]        ofs_val,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] lane_out,
    output logic              busy
);

    localparam logic [Z_W-1:0] Z_STEP = Z_W'(BITS_PER_CYC);
    localparam logic [Z_W-1:0] Z_LAST = Z_W'(LANE_W - BITS_PER_CYC);

    rho_state_e              state, stateNext;
    logic [LANE_W-1:0]       src;
    logic [Z_W-1:0]          r, rLoad, z;
    logic [BITS_PER_CYC-1:0] sliceBits;
    logic                    accept;

`ifdef RHO_OFFSET_OVERRIDE_EN
    assign rLoad = ofs_sel ? Z_W'(ofs_val) : Z_W'(rho_offset(lane_id, LANE_W));
`else
    assign rLoad = Z_W'(rho_offset(lane_id, LANE_W));
`endif

    assign accept = (state == IDLE) && in_valid;

    rho_bit_slice #(
        .LANE_W       (LANE_W),
        .BITS_PER_CYC (BITS_PER_CYC),
        .Z_W          (Z_W)
    ) u_slice (
        .src  (src),
        .z    (z),
        .r    (r),
        .bits (sliceBits)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    stateNext = ROT;
            end
            ROT: begin
                if (z == Z_LAST)
                    stateNext = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // lane_out is written chunk by chunk during ROT and otherwise left untouched,
    // so it stays stable through HOLD and the following IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src      <= '0;
            r        <= '0;
            z        <= '0;
            lane_out <= '0;
        end else if (accept) begin
            src <= lane_in;
            r   <= rLoad;
            z   <= '0;
        end else if (state == ROT) begin
            lane_out[z +: BITS_PER_CYC] <= sliceBits;
            z                           <= z + Z_STEP;
        end
    end

endmodule

// File: tb/tb_rho_rotate_engine.sv
// Self-checking bench: a 64-bit/1-bit engine and an 8-bit/2-bit engine against a rotate model.
module tb_rho_rotate_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b0, busy64;
    logic [63:0] li64 = '0, lo64;
    logic [4:0]  id64 = '0;
    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, busy8;
    logic [7:0]  li8 = '0, lo8;
    logic [4:0]  id8 = '0;
    logic        osel = 1'b0;
    logic [5:0]  oval = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rho_rotate_engine #(.LANE_W(64), .BITS_PER_CYC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .lane_in(li64), .lane_id(id64),
`ifdef RHO_OFFSET_OVERRIDE_EN
        .ofs_sel(osel), .ofs_val(oval),
`endif
        .out_valid(ov64), .out_ready(or64), .lane_out(lo64), .busy(busy64));

    rho_rotate_engine #(.LANE_W(8), .BITS_PER_CYC(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .lane_in(li8), .lane_id(id8),
`ifdef RHO_OFFSET_OVERRIDE_EN
        .ofs_sel(1'b0), .ofs_val(6'd0),
`endif
        .out_valid(ov8), .out_ready(or8), .lane_out(lo8), .busy(busy8));

    int tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    // Reference: bit i of the source lands at (i + r) mod W.
    function automatic logic [63:0] model(input logic [63:0] x, input int id, input int w,
                                          input logic sel, input int ov);
        logic [63:0] y;
        int          r;
        r = sel ? (ov % w) : ((id > 24) ? 0 : tab[id] % w);
        y = '0;
        for (int i = 0; i < w; i++)
            y[(i + r) % w] = x[i];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit s8);  return s8 ? ir8 : ir64;   endfunction
    function automatic logic ovl(input bit s8);  return s8 ? ov8 : ov64;   endfunction
    function automatic logic bsy(input bit s8);  return s8 ? busy8 : busy64; endfunction
    function automatic logic [63:0] lo(input bit s8); return s8 ? {56'd0, lo8} : lo64; endfunction

    task automatic set_in(input bit s8, input logic v, input logic [63:0] d, input logic [4:0] id);
        if (s8) begin iv8 = v; li8 = d[7:0]; id8 = id; end
        else    begin iv64 = v; li64 = d; id64 = id; end
    endtask

    task automatic set_ordy(input bit s8, input logic v);
        if (s8) or8 = v; else or64 = v;
    endtask

    // One lane through accept, rotate, optional stall in HOLD, and release.
    task automatic run(input bit s8, input logic [63:0] d, input logic [4:0] id, input int stall);
        logic [63:0] exp;
        int          w, n, cnt;
        bit          done;
        w   = s8 ? 8 : 64;
        n   = s8 ? 4 : 64;
        exp = model(d, id, w, osel, int'(oval));
        @(negedge clk);
        chk("in_ready_idle", 64'(rdy(s8)), 64'd1);
        set_in(s8, 1'b1, d, id);
        @(posedge clk); #1;
        set_in(s8, 1'b0, ~d, id);
        chk("busy_rot", 64'(bsy(s8)), 64'd1);
        chk("in_ready_rot", 64'(rdy(s8)), 64'd0);
        cnt  = 0;
        done = 0;
        while (!done && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (ovl(s8)) done = 1;
        end
        chk("latency", 64'(cnt), 64'(n));
        chk("lane_out", lo(s8), exp);
        for (int i = 0; i < stall; i++) begin
            set_in(s8, 1'b1, ~d, 5'd3);
            @(posedge clk); #1;
            chk("hold_valid", 64'(ovl(s8)), 64'd1);
            chk("hold_stable", lo(s8), exp);
            chk("hold_in_ready", 64'(rdy(s8)), 64'd0);
        end
        set_in(s8, 1'b0, d, id);
        set_ordy(s8, 1'b1);
        @(posedge clk); #1;
        set_ordy(s8, 1'b0);
        chk("idle_busy", 64'(bsy(s8)), 64'd0);
        chk("idle_valid", 64'(ovl(s8)), 64'd0);
        chk("idle_stable", lo(s8), exp);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 64'(ir64), 64'd1);
        chk("rst_out_valid", 64'(ov64), 64'd0);
        chk("rst_busy", 64'(busy64), 64'd0);
        chk("rst_lane_out", lo64, 64'd0);
        chk("rst_lane_out8", 64'(lo8), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run(0, 64'h1, 5'd1, 0);
        chk("dir_rot1", lo64, 64'h2);
        run(0, 64'h1, 5'd2, 0);
        chk("dir_rot62", lo64, 64'h4000000000000000);
        run(0, 64'hDEADBEEF_01234567, 5'd0, 0);
        chk("dir_rot0", lo64, 64'hDEADBEEF_01234567);
        run(1, 64'h01, 5'd2, 0);
        chk("dir8_rot6", 64'(lo8), 64'h40);
        run(1, 64'h01, 5'd27, 0);
        chk("dir8_pass", 64'(lo8), 64'h01);
        run(0, 64'h0123_4567_89AB_CDEF, 5'd9, 10);
        run(1, 64'hA5, 5'd4, 10);

        // Abort a lane mid-rotation with reset.
        @(negedge clk);
        set_in(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
        @(posedge clk); #1;
        set_in(0, 1'b0, 64'h0, 5'd0);
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(ov64), 64'd0);
        chk("abort_in_ready", 64'(ir64), 64'd1);
        chk("abort_busy", 64'(busy64), 64'd0);
        chk("abort_lane_out", lo64, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run(0, 64'h1, 5'd3, 0);
        chk("post_abort", lo64, 64'h10000000);

`ifdef RHO_OFFSET_OVERRIDE_EN
        osel = 1'b1;
        oval = 6'd5;
        run(0, 64'h1, 5'd7, 0);
        chk("override", lo64, 64'h20);
        osel = 1'b0;
        oval = 6'd0;
`endif

        for (int t = 0; t < 20; t++) begin
            run(0, {$urandom, $urandom}, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
            run(1, 64'($urandom_range(0, 255)), 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rho_rotate_engine.md
# rho_rotate_engine

Parametrised Keccak ρ (rho) lane-rotation engine and successor to the fixed 64-bit, one-bit-per-cycle rotator. Lane width and bits per cycle are set by parameters, and lanes are exchanged through valid/ready handshakes on both sides. Offsets come from the standard ρ table, reduced mod lane width. It sits between the θ stage and the π/χ datapath in the permutation core.

## Interface
- LANE_W, 64: lane width in bits. Power of two, 8..64.
- BITS_PER_CYC, 1: bits rotated per cycle. Power of two, must divide LANE_W.
- Z_W, $clog2(LANE_W): derived; do not override.
- clk  in  1  clock. All flops on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  lane_in/lane_id valid.
- in_ready  out  1  engine can accept a lane.
- lane_in  in  LANE_W  source lane.
- lane_id  in  5  lane index, x+5y, 0..24.
- out_valid  out  1  lane_out holds the complete rotated lane.
- out_ready  in  1  consumer accepts lane_out.
- lane_out  out  LANE_W  rotated lane.
- busy  out  1  state != IDLE.

## Operation
- States and transitions:
  - IDLE: in_ready=1. On in_valid: capture lane_in into src, load r = OFFSET[lane_id] & (LANE_W-1), clear z, go to ROT.
  - ROT: each cycle, for k in 0..BITS_PER_CYC-1: lane_out[z+k] <= src[(z+k-r) mod LANE_W]. Then z <= z+BITS_PER_CYC. If z == LANE_W-BITS_PER_CYC, go to HOLD.
  - HOLD: out_valid=1. On out_ready, go to IDLE.
- Result is lane_out = rotate-left(lane_in, r). Bit z comes from src bit (z-r) mod LANE_W.
- Index arithmetic is Z_W bits wide and wraps by masking. No compare-and-add correction.
- OFFSET table by lane_id 0..24: 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14.
- lane_id 25..31: r=0, so the lane passes through unrotated.
- in_ready is 0 outside IDLE. Input is never accepted during ROT or HOLD.
- lane_out is only meaningful while out_valid=1. It holds stable through HOLD until the handshake completes, and again through IDLE until the next ROT cycle.

## Timing
- Reset (async assert, sync deassert by the system): state=IDLE, z=0, src=0, r=0, lane_out=0, out_valid=0, in_ready=1, busy=0.
- Reset asserted mid-ROT or mid-HOLD: the in-flight lane is discarded and nothing is emitted.
- Input accepted at edge E0. out_valid rises after edge E0+LANE_W/BITS_PER_CYC.
- Minimum lane period is LANE_W/BITS_PER_CYC+2 cycles: accept, rotate, HOLD, IDLE.
- out_ready held low: the engine stays in HOLD indefinitely with lane_out stable.
- out_ready high on the first HOLD cycle: state is IDLE on the next cycle.
- out_ready is ignored outside HOLD. in_valid is ignored outside IDLE.
- BITS_PER_CYC==LANE_W: exactly one ROT cycle.

## Configuration
- RHO_OFFSET_OVERRIDE_EN
  - Defined: adds ports ofs_sel (in, 1) and ofs_val (in, 6), sampled with the input handshake. When ofs_sel=1, r = ofs_val & (LANE_W-1) replaces the table value. Used for debug and for non-Keccak rotations.
  - Undefined: neither port exists and r always comes from the table.

## Structure
- Shared package rho_pkg holds:
  - the state typedef: IDLE, ROT, HOLD;
  - the 25-entry RHO_OFFSET constant (6-bit entries);
  - the function rho_offset(lane_id, lane_w) that returns the masked offset, 0 for ids above 24.
- One sub-module, rho_bit_slice: combinational selection of BITS_PER_CYC source bits given z and r, instantiated once.
- The top level holds the FSM, z counter, src/r registers and the lane_out write.

## Test plan
- LANE_W=64, P=1, lane_in=64'h1, lane_id=1: lane_out=64'h2, with out_valid rising exactly 64 cycles after acceptance.
- LANE_W=64, lane_in=64'h1, lane_id=2 (r=62): lane_out=64'h4000000000000000. lane_id=0 with lane_in=64'hDEADBEEF_01234567 returns the input unchanged.
- LANE_W=8, BITS_PER_CYC=2, lane_in=8'h01, lane_id=2 (r=62 mod 8=6): lane_out=8'h40, out_valid after 4 cycles. lane_id=27 gives 8'h01 (pass-through).
- Back-pressure: out_ready=0 for 10 cycles in HOLD. out_valid stays 1, lane_out stays stable, in_ready stays 0, and a concurrent in_valid is not accepted.
- Reset pulse at ROT cycle 20: all outputs reach reset values immediately. The next lane (lane_id=3, 64'h1) returns 64'h10000000 with no residue from the aborted lane.
- With RHO_OFFSET_OVERRIDE_EN: ofs_sel=1, ofs_val=5, lane_in=64'h1, lane_id=7: lane_out=64'h20.
